// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, one or two stop bits,
// and a single-word holding register handed off with valid/ready plus a sticky overrun flag.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           o_dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_sync;
  logic [1:0]           r_live;
  logic                 r_armed;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;

  logic w_rx_s;
  logic w_tick_half;
  logic w_tick_bit;
  logic w_frame_start;
  logic w_shift_en;
  logic w_par_en;
  logic w_stop_en;
  logic w_complete;
  logic w_cnt_run;

  assign w_rx_s      = r_sync[1];
  assign w_tick_half = (r_cnt == HALF_LAST);
  assign w_tick_bit  = (r_cnt == BIT_LAST);
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

  // The synchronizer resets to 1, so a start is only armed once a genuine
  // high line level has propagated through both flops after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_live  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_live <= {r_live[0], 1'b1};
      if (r_live[1] && w_rx_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_shift_en    = 1'b0;
    w_par_en      = 1'b0;
    w_stop_en     = 1'b0;
    w_complete    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_armed && !w_rx_s) begin
          w_state_nxt   = S_START;
          w_frame_start = 1'b1;
        end
      end
      S_START: begin
        if (w_tick_half) begin
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick_bit) begin
          w_shift_en = 1'b1;
          if (r_bit == DATA_LAST) begin
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_tick_bit) begin
          w_par_en    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick_bit) begin
          w_stop_en = 1'b1;
          if (r_bit == STOP_LAST) begin
            w_complete  = 1'b1;
            w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The bit-period counter restarts on every state change and every sample point.
  assign w_cnt_run = (r_state != S_IDLE) && (r_state != S_WAIT_HIGH) &&
                     (w_state_nxt == r_state) && !w_tick_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_run) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // r_bit counts data bits, then is reused to count stop bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_bit  <= '0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end else if (w_shift_en) begin
        r_bit   <= (r_bit == DATA_LAST) ? '0 : r_bit + BW'(1);
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end else if (w_par_en) begin
        r_perr <= (^r_shift) ^ w_rx_s ^ (PARITY == 1);
      end else if (w_stop_en) begin
        r_bit <= r_bit + BW'(1);
        if (!w_rx_s) begin
          r_ferr <= 1'b1;
        end
      end
    end
  end

  // Hand-off: the word transfers on any rising edge where rx_valid && rx_ready;
  // rx_valid never drops without that handshake, and a completion that finds the
  // word still unaccepted replaces it and raises the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (w_complete) begin
      rx_data    <= r_shift;
      parity_err <= r_perr;
      frame_err  <= r_ferr | ~w_rx_s;
      rx_valid   <= 1'b1;
      if (rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E2 instance driven by directed and random
// frames, checked every cycle against a sample-time model of the serial protocol.
module tb_uart_rx_cfg;

  localparam int C = 16;
  localparam int H = C / 2;

  int cfg_d [2] = '{8, 7};
  int cfg_p [2] = '{0, 2};
  int cfg_s [2] = '{1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_l     [2];
  logic       ready_l  [2];
  int         ready_mode [2] = '{0, 0};
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [8:0] dout     [2];
  logic       valid_o  [2];
  logic       perr_o   [2];
  logic       ferr_o   [2];
  logic       ovr_o    [2];
  logic       busy_o   [2];
  logic [2:0] dbg_o    [2];

  assign dout[0] = {1'b0, data_a};
  assign dout[1] = {2'b00, data_b};

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .rx_data(data_a), .rx_valid(valid_o[0]),
    .rx_ready(ready_l[0]), .parity_err(perr_o[0]), .frame_err(ferr_o[0]),
    .overrun(ovr_o[0]), .busy(busy_o[0]), .o_dbg_state(dbg_o[0])
  );

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .rx_data(data_b), .rx_valid(valid_o[1]),
    .rx_ready(ready_l[1]), .parity_err(perr_o[1]), .frame_err(ferr_o[1]),
    .overrun(ovr_o[1]), .busy(busy_o[1]), .o_dbg_state(dbg_o[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string name, input int k,
                              input logic [8:0] act, input logic [8:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
  endfunction

  // Model: mode 0 idle, 1 in frame (timed from start detect m_t0), 2 waiting for high.
  longint     cyc = 0;
  bit         started = 0;
  int         m_mode  [2];
  longint     m_t0    [2];
  bit         m_armed [2];
  int         m_gen   [2];
  logic [1:0] m_pipe  [2];
  logic [8:0] m_data  [2];
  bit         m_perr  [2];
  bit         m_ferr  [2];
  logic       e_valid [2];
  logic       e_perr  [2];
  logic       e_ferr  [2];
  logic       e_ovr   [2];
  logic [8:0] e_data  [2];

  function automatic void model_step(input int k);
    bit     rs;
    bit     cmpl;
    longint r;
    int     idx;
    int     ones;
    rs   = m_pipe[k][1];
    cmpl = 0;
    if (!rst_n) begin
      m_pipe[k] = 2'b11; m_mode[k] = 0; m_gen[k] = 0; m_armed[k] = 0;
      e_valid[k] = 0; e_perr[k] = 0; e_ferr[k] = 0; e_ovr[k] = 0; e_data[k] = 0;
      return;
    end
    if (m_gen[k] >= 2 && rs) m_armed[k] = 1;
    case (m_mode[k])
      0: if (m_armed[k] && !rs) begin
        m_mode[k] = 1; m_t0[k] = cyc; m_data[k] = 0; m_perr[k] = 0; m_ferr[k] = 0;
      end
      1: begin
        r = cyc - m_t0[k];
        if (r == H) begin
          if (rs) m_mode[k] = 0;
        end else if (r > H && ((r - H) % C) == 0) begin
          idx = int'((r - H) / C) - 1;
          if (idx < cfg_d[k]) m_data[k][idx] = rs;
          else if (cfg_p[k] != 0 && idx == cfg_d[k]) begin
            ones = ($countones(m_data[k]) + int'(rs)) % 2;
            m_perr[k] = (cfg_p[k] == 1) ? (ones == 0) : (ones == 1);
          end else begin
            if (!rs) m_ferr[k] = 1;
            if (idx == cfg_d[k] + ((cfg_p[k] != 0) ? 1 : 0) + cfg_s[k] - 1) begin
              cmpl = 1;
              m_mode[k] = rs ? 0 : 2;
            end
          end
        end
      end
      default: if (rs) m_mode[k] = 0;
    endcase
    if (cmpl) begin
      if (e_valid[k] && !ready_l[k]) e_ovr[k] = 1;
      e_valid[k] = 1; e_data[k] = m_data[k]; e_perr[k] = m_perr[k]; e_ferr[k] = m_ferr[k];
    end else if (e_valid[k] && ready_l[k]) begin
      e_valid[k] = 0; e_perr[k] = 0; e_ferr[k] = 0; e_ovr[k] = 0;
    end
    m_pipe[k] = {m_pipe[k][0], rx_l[k]};
    if (m_gen[k] < 2) m_gen[k]++;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) model_step(k);
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk("rx_valid", k, valid_o[k], e_valid[k]);
        chk("busy", k, busy_o[k], m_mode[k] != 0);
        chk("wait_high", k, dbg_o[k] == 3'd5, m_mode[k] == 2);
        chk("parity_err", k, perr_o[k], e_perr[k]);
        chk("frame_err", k, ferr_o[k], e_ferr[k]);
        chk("overrun", k, ovr_o[k], e_ovr[k]);
        if (e_valid[k]) chk("rx_data", k, dout[k], e_data[k]);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (ready_mode[k] == 2) ready_l[k] = 1'($urandom_range(0, 1));
  end

  task automatic set_ready(input int k, input int m);
    ready_mode[k] = m;
    if (m < 2) ready_l[k] = (m == 1);
  endtask

  task automatic drive(input int k, input logic v, input int n);
    @(negedge clk);
    rx_l[k] = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [8:0] w_in, input bit bad_par,
                            input logic [1:0] stops, input int low_after);
    logic [8:0] w;
    logic       p;
    w = w_in & 9'((1 << cfg_d[k]) - 1);
    drive(k, 1'b0, C);
    for (int i = 0; i < cfg_d[k]; i++) drive(k, w[i], C);
    if (cfg_p[k] != 0) begin
      p = ^w;
      if (cfg_p[k] == 1) p = ~p;
      drive(k, p ^ bad_par, C);
    end
    for (int j = 0; j < cfg_s[k]; j++) drive(k, stops[j], C);
    if (low_after > 0) drive(k, 1'b0, low_after);
    drive(k, 1'b1, 1);
  endtask

  task automatic wait_valid(input int k, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid_o[k] === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  bit         ok;
  bit         saw_busy;
  int         n_valid;
  logic [8:0] w;
  logic [8:0] w5a;
  bit         bad;
  logic [1:0] stops;
  int         low_after;

  initial begin
    rst_n = 1'b0;
    rx_l[0] = 1'b1; rx_l[1] = 1'b1;
    ready_l[0] = 1'b0; ready_l[1] = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, valid_o[k], 0);
      chk("rst_data", k, dout[k], 0);
      chk("rst_busy", k, busy_o[k], 0);
      chk("rst_overrun", k, ovr_o[k], 0);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 0x41 with ready held high: one-cycle valid, clean flags.
    set_ready(0, 1);
    fork
      send_frame(0, 9'h041, 0, 2'b11, 0);
      begin
        wait_valid(0, 400, ok);
        chk("valid_seen_41", 0, ok, 1);
        chk("data_41", 0, dout[0], 9'h041);
        chk("perr_41", 0, perr_o[0], 0);
        chk("ferr_41", 0, ferr_o[0], 0);
        @(negedge clk);
        chk("valid_1cyc_41", 0, valid_o[0], 0);
      end
    join
    repeat (10) @(negedge clk);

    // 7E2 0x35 with an inverted parity bit.
    set_ready(1, 1);
    fork
      send_frame(1, 9'h035, 1, 2'b11, 0);
      begin
        wait_valid(1, 400, ok);
        chk("valid_seen_35", 1, ok, 1);
        chk("data_35", 1, dout[1], 9'h035);
        chk("perr_35", 1, perr_o[1], 1);
        chk("ferr_35", 1, ferr_o[1], 0);
      end
    join
    repeat (10) @(negedge clk);

    // Second stop bit low and the line held low: frame error, then WAIT_HIGH.
    fork
      send_frame(1, 9'h02A, 0, 2'b01, 40);
      begin
        wait_valid(1, 400, ok);
        chk("valid_seen_2a", 1, ok, 1);
        chk("data_2a", 1, dout[1], 9'h02A);
        chk("ferr_2a", 1, ferr_o[1], 1);
        chk("state_wait_high", 1, dbg_o[1], 3'd5);
        chk("busy_wait_high", 1, busy_o[1], 1);
      end
    join
    repeat (4) @(negedge clk);
    chk("state_idle_after_high", 1, dbg_o[1], 3'd0);

    // Short low glitch on the idle line: a false start, no word.
    repeat (10) @(negedge clk);
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 1);
    saw_busy = 0; n_valid = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_o[0]) saw_busy = 1;
      if (valid_o[0]) n_valid++;
    end
    chk("glitch_detected", 0, saw_busy, 1);
    chk("glitch_no_valid", 0, 9'(n_valid), 0);
    chk("glitch_busy_clear", 0, busy_o[0], 0);

    // Two frames with ready low: second overwrites, overrun set, then handshake clears it.
    set_ready(0, 0);
    send_frame(0, 9'h011, 0, 2'b11, 0);
    repeat (4) @(negedge clk);
    chk("held_11", 0, dout[0], 9'h011);
    chk("ovr_after_first", 0, ovr_o[0], 0);
    send_frame(0, 9'h022, 0, 2'b11, 0);
    repeat (4) @(negedge clk);
    chk("held_22", 0, dout[0], 9'h022);
    chk("valid_22", 0, valid_o[0], 1);
    chk("ovr_22", 0, ovr_o[0], 1);
    set_ready(0, 1);
    @(negedge clk);
    chk("valid_clear_hs", 0, valid_o[0], 0);
    chk("ovr_clear_hs", 0, ovr_o[0], 0);
    repeat (10) @(negedge clk);

    // Reset in the middle of data bit 3 of 0x5A, then a clean 0x5A.
    w5a = 9'h05A;
    drive(0, 1'b0, C);
    for (int i = 0; i < 3; i++) drive(0, w5a[i], C);
    drive(0, w5a[3], H);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy", 0, busy_o[0], 0);
    chk("midrst_valid", 0, valid_o[0], 0);
    chk("midrst_data", 0, dout[0], 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    fork
      send_frame(0, 9'h05A, 0, 2'b11, 0);
      begin
        wait_valid(0, 400, ok);
        chk("valid_seen_5a", 0, ok, 1);
        chk("data_5a", 0, dout[0], 9'h05A);
      end
    join
    repeat (10) @(negedge clk);

    // Reset released with the line low: nothing starts until high then low again.
    rx_l[0] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_o[0]) saw_busy = 1;
    end
    chk("low_release_idle", 0, saw_busy, 0);
    rx_l[0] = 1'b1;
    repeat (10) @(negedge clk);
    fork
      send_frame(0, 9'h03C, 0, 2'b11, 0);
      begin
        wait_valid(0, 400, ok);
        chk("valid_seen_3c", 0, ok, 1);
        chk("data_3c", 0, dout[0], 9'h03C);
      end
    join

    for (int k = 0; k < 2; k++) begin
      set_ready(k, 2);
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 9) == 0) begin
          drive(k, 1'b0, $urandom_range(1, 12));
          drive(k, 1'b1, 1);
        end else begin
          w         = 9'($urandom);
          bad       = ($urandom_range(0, 3) == 0);
          stops     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
          low_after = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 30) : 0;
          send_frame(k, w, bad, stops, low_after);
        end
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      set_ready(k, 1);
      repeat (300) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
